mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, between exe_stage and wb_stage.
- Registers the EXE→MEM bus and aligns and extends load data returned by the synchronous data SRAM (request issued in EXE).
- Produces the MEM→WB bus consumed by wb_stage.
- Also drives the forwarding/hazard bus to ID and a flush-pending flag to EXE.

Parameters:
- ES_TO_MS_BUS_WD, 158, width of EXE→MEM bus.
- MS_TO_WS_BUS_WD, 155, width of MEM→WB bus.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_allowin  out  1  MEM can accept a new instruction
- es_to_ms_valid  in  1  EXE presents a valid instruction
- es_to_ms_bus  in  158  {ex[157], exccode[156:152], bd[151], badvaddr[150:119], eret[118], mtc0[117], cp0_addr[116:109], cp0_wdata[108:77], res_from_cp0[76], load_op[75:73], rf_we[72:69], dest[68:64], alu_result[63:32], pc[31:0]}
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  valid toward WB
- ms_to_ws_bus  out  155  {ex[154], exccode[153:149], bd[148], badvaddr[147:116], eret[115], mtc0[114], cp0_addr[113:106], cp0_wdata[105:74], res_from_cp0[73], rf_we[72:69], dest[68:64], final_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  SRAM read data, valid in the first cycle the instruction is in MEM
- handle_ex  in  1  exception/eret taken in WB; flush
- ms_to_ds_bus  out  43  {fwd_valid[42], fwd_we[41:38], fwd_dest[37:33], fwd_result[32:1], fwd_blocking[0]}
- ms_ex_flush  out  1  ms_valid && (ex || eret); EXE suppresses stores when high

Behaviour:
- Handshake and valid register:
  - ms_ready_go = 1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_valid: reset→0; else handle_ex→0 (priority); else if ms_allowin→es_to_ms_valid.
  - Bus register loads on es_to_ms_valid && ms_allowin. It holds otherwise and is not cleared by reset.
  - ms_to_ws_valid = ms_valid && !handle_ex.
- Read-data hold:
  - hold_vld: reset→0; cleared on every bus-register load; set in the first valid cycle.
  - hold_data captures data_sram_rdata when hold_vld = 0 && ms_valid.
  - ld_raw = hold_vld ? hold_data : data_sram_rdata. A WB stall therefore never loses load data.
- Load formatting, off = alu_result[1:0]:
  - load_op 0: ALU/non-load; result = alu_result; rf_we passed through.
  - load_op 1 LB / 2 LBU: byte at off, sign- or zero-extended.
  - load_op 3 LH / 4 LHU: halfword at off[1], sign- or zero-extended.
  - load_op 5 LW: ld_raw.
  - load_op 6 LWL / 7 LWR: see Optional Feature.
  - For load_op 1–5, rf_we = 4'hF whenever the incoming rf_we is non-zero.
- Exception cases:
  - If ex = 1, final_result = alu_result and the output rf_we = 0.
  - All other fields pass through unchanged.
- Forwarding bus to ID:
  - fwd_valid = ms_valid && !ex && (rf_we != 0).
  - fwd_we, fwd_dest, fwd_result are the same values sent to WB.
  - fwd_blocking = ms_valid && res_from_cp0. ID stalls on this: an mfc0 result is not yet available.
- Reset mid-operation: valid clears next edge; hold_vld clears; outputs invalid.
- Simultaneous handle_ex and es_to_ms_valid: the bus may load, but ms_valid = 0.

Optional Feature:
- Macro: MS_UNALIGNED_LD_EN.
- Defined:
  - LWL: result = ld_raw << 8*(3-off); rf_we = {4'b1000, 4'b1100, 4'b1110, 4'b1111}[off].
  - LWR: result = ld_raw >> 8*off; rf_we = {4'b1111, 4'b0111, 4'b0011, 4'b0001}[off].
- Undefined: load_op 6/7 produce rf_we = 0 and result = alu_result. The instruction still flows to WB and retires with no write.

Test Plan:
- LB, alu_result=0x1003, rdata=0x80AABBCC → final_result=0xFFFFFF80, rf_we=4'hF, one cycle in MEM.
- LHU, off=2, rdata=0x8001_1234, ws_allowin low 3 cycles → held result 0x00008001 is stable while rdata changes to 0xDEADBEEF.
- Instruction with ex=1, exccode=4 (AdEL), rf_we=F → bus ex=1, rf_we=0, fwd_valid=0, ms_ex_flush=1.
- handle_ex pulse while ms_valid=1 and es_to_ms_valid=1 → ms_valid=0 next cycle, ms_to_ws_valid=0 in the flush cycle.
- With MS_UNALIGNED_LD_EN: LWL off=1, rdata=0x11223344 → result=0x33440000, rf_we=4'b1100. LWR off=2 → result=0x00001122, rf_we=4'b0011.
- mfc0 (res_from_cp0=1, dest=8) in MEM → fwd_blocking=1. Reset asserted → ms_valid=0, ms_to_ws_valid=0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: registers the EXE bus, aligns/extends SRAM load data, feeds WB and ID.
// Optional MS_UNALIGNED_LD_EN adds LWL/LWR merge results and byte-enable masks.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 158,
  parameter int MS_TO_WS_BUS_WD = 155
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       handle_ex,
  output logic [42:0]                ms_to_ds_bus,
  output logic                       ms_ex_flush
);

  logic                       r_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic                       r_hold_vld;
  logic [31:0]                r_hold_data;

  logic        w_load;
  logic        w_ex;
  logic        w_eret;
  logic        w_cp0;
  logic [2:0]  w_op;
  logic [3:0]  w_we;
  logic [3:0]  w_we_full;
  logic [4:0]  w_dest;
  logic [31:0] w_alu;
  logic [1:0]  w_off;
  logic [31:0] w_raw;
  logic [31:0] w_rsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_res;
  logic [3:0]  w_rfwe;
  logic        w_fwd_vld;

  assign ms_allowin = !r_valid || ws_allowin;
  assign w_load     = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset)
      r_valid <= 1'b0;
    else if (handle_ex)
      r_valid <= 1'b0;
    else if (ms_allowin)
      r_valid <= es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (w_load)
      r_bus <= es_to_ms_bus;
  end

  // SRAM data is only valid in the first MEM cycle; keep it across WB stalls
  always_ff @(posedge clk) begin
    if (reset)
      r_hold_vld <= 1'b0;
    else if (w_load)
      r_hold_vld <= 1'b0;
    else if (r_valid)
      r_hold_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!r_hold_vld && r_valid)
      r_hold_data <= data_sram_rdata;
  end

  assign w_ex   = r_bus[157];
  assign w_eret = r_bus[118];
  assign w_cp0  = r_bus[76];
  assign w_op   = r_bus[75:73];
  assign w_we   = r_bus[72:69];
  assign w_dest = r_bus[68:64];
  assign w_alu  = r_bus[63:32];
  assign w_off  = w_alu[1:0];

  assign w_raw     = r_hold_vld ? r_hold_data : data_sram_rdata;
  assign w_rsh     = w_raw >> {w_off, 3'b000};
  assign w_byte    = w_rsh[7:0];
  assign w_half    = w_off[1] ? w_raw[31:16] : w_raw[15:0];
  assign w_we_full = (w_we != 4'h0) ? 4'hF : 4'h0;

  always_comb begin
    w_res  = w_alu;
    w_rfwe = w_we;
    unique case (w_op)
      3'd0: begin
        w_res  = w_alu;
        w_rfwe = w_we;
      end
      3'd1: begin
        w_res  = {{24{w_byte[7]}}, w_byte};
        w_rfwe = w_we_full;
      end
      3'd2: begin
        w_res  = {24'h0, w_byte};
        w_rfwe = w_we_full;
      end
      3'd3: begin
        w_res  = {{16{w_half[15]}}, w_half};
        w_rfwe = w_we_full;
      end
      3'd4: begin
        w_res  = {16'h0, w_half};
        w_rfwe = w_we_full;
      end
      3'd5: begin
        w_res  = w_raw;
        w_rfwe = w_we_full;
      end
`ifdef MS_UNALIGNED_LD_EN
      3'd6: begin
        w_res  = w_raw << {~w_off, 3'b000};
        w_rfwe = 4'hF << ~w_off;
      end
      3'd7: begin
        w_res  = w_rsh;
        w_rfwe = 4'hF >> w_off;
      end
`else
      3'd6: begin
        w_res  = w_alu;
        w_rfwe = 4'h0;
      end
      3'd7: begin
        w_res  = w_alu;
        w_rfwe = 4'h0;
      end
`endif
    endcase
    if (w_ex) begin
      w_res  = w_alu;
      w_rfwe = 4'h0;
    end
  end

  assign ms_to_ws_valid = r_valid && !handle_ex;
  assign ms_ex_flush    = r_valid && (w_ex || w_eret);
  assign w_fwd_vld      = r_valid && !w_ex && (w_rfwe != 4'h0);

  assign ms_to_ws_bus = {r_bus[157:76], w_rfwe, w_dest,
                         w_res, r_bus[31:0]};

  assign ms_to_ds_bus = {w_fwd_vld, w_rfwe, w_dest, w_res,
                         r_valid && w_cp0};

endmodule
